// File: rtl/issue_pkg.sv
// Shared types for the dual-issue scheduler: FSM states, per-slot decode info,
// stall-cause bit positions and the intra-pair hazard check.
package issue_pkg;

  typedef enum logic [0:0] {
    StPair = 1'b0,
    StHalf = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic       we;
    logic [4:0] waddr;
    logic       re1;
    logic [4:0] raddr1;
    logic       re2;
    logic [4:0] raddr2;
    logic       is_mem;
    logic       is_div;
    logic       is_csr;
  } slot_info_t;

  localparam int unsigned StallHazard = 0;
  localparam int unsigned StallSb     = 1;
  localparam int unsigned StallDrain  = 2;

  // True when line2 must not issue in the same cycle as line1.
  function automatic logic pair_hazard(slot_info_t l1, slot_info_t l2);
    logic raw;
    logic waw;
    raw = l1.we && (l1.waddr != 5'd0) &&
          ((l2.re1 && (l2.raddr1 == l1.waddr)) || (l2.re2 && (l2.raddr2 == l1.waddr)));
    waw = l1.we && l2.we && (l1.waddr != 5'd0) && (l1.waddr == l2.waddr);
    return raw || waw || (l1.is_mem && l2.is_mem) || (l1.is_div && l2.is_div) ||
           l1.is_csr || l2.is_csr;
  endfunction

endpackage

// File: rtl/issue_sched_if.sv
// ID-stage pair bundle between decode (master) and the issue scheduler (slave).
interface issue_sched_if;
  import issue_pkg::*;

  logic [1:0] id_valid;
  slot_info_t line1;
  slot_info_t line2;
  logic       line1_read_ready;
  logic       line2_read_ready;
  logic [1:0] issue;
  logic       id_allowin;
  logic [2:0] stall_cause;

  modport master (
    output id_valid, line1, line2, line1_read_ready, line2_read_ready,
    input  issue, id_allowin, stall_cause
  );

  modport slave (
    input  id_valid, line1, line2, line1_read_ready, line2_read_ready,
    output issue, id_allowin, stall_cause
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Busy bits for registers awaiting a multi-cycle divider result, with per-lane
// source lookups. A set and clear to the same register in one cycle leaves it busy.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int unsigned REG_NUM = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       set_i,
  input  logic [4:0] set_addr_i,
  input  logic       clr_i,
  input  logic [4:0] clr_addr_i,
  input  slot_info_t line1_i,
  input  slot_info_t line2_i,
  output logic       line1_busy_o,
  output logic       line2_busy_o
);

  logic [REG_NUM-1:0] busy_q, busy_d;

  function automatic logic src_busy(logic [REG_NUM-1:0] v, logic re, logic [4:0] a);
    return re && (a != 5'd0) && v[a];
  endfunction

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i && (set_addr_i != 5'd0)) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign line1_busy_o = src_busy(busy_q, line1_i.re1, line1_i.raddr1) ||
                        src_busy(busy_q, line1_i.re2, line1_i.raddr2);
  assign line2_busy_o = src_busy(busy_q, line2_i.re1, line2_i.raddr1) ||
                        src_busy(busy_q, line2_i.re2, line2_i.raddr2);

endmodule

// File: rtl/issue_sched.sv
// Dual-issue scheduler between ID and EX. Define ISSUE_SCHED_DUAL_EN to allow both
// lanes to issue in one cycle; otherwise every valid line2 issues alone via HALF.
module issue_sched
  import issue_pkg::*;
#(
  parameter int unsigned CSR_DRAIN = 3,
  parameter int unsigned REG_NUM   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          ex_allowin_i,
  input  logic          div_done_i,
  input  logic [4:0]    div_waddr_i,
  issue_sched_if.slave  id
);

  localparam int unsigned CntW = $clog2(CSR_DRAIN + 1);

  issue_state_e    state_q, state_d;
  logic [CntW-1:0] drain_q, drain_d;
  logic            l1_busy, l2_busy, drain_idle, l1_ok, l2_ok, hazard, pair_ok;
  logic            csr_issue, div_set;
  logic [4:0]      div_set_addr;
  logic [1:0]      issue;
  logic            allowin;
  logic [2:0]      stall;

  assign drain_idle = (drain_q == '0);
  assign l1_ok  = id.id_valid[0] && id.line1_read_ready && !l1_busy && drain_idle && ex_allowin_i;
  assign l2_ok  = id.id_valid[1] && id.line2_read_ready && !l2_busy && drain_idle && ex_allowin_i;
  assign hazard = pair_hazard(id.line1, id.line2);

`ifdef ISSUE_SCHED_DUAL_EN
  assign pair_ok = !hazard;
`else
  assign pair_ok = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    issue   = 2'b00;
    allowin = 1'b0;
    stall   = 3'b000;
    case (state_q)
      StPair: begin
        if (l1_ok) begin
          issue[0] = 1'b1;
          if (l2_ok && pair_ok) begin
            issue[1] = 1'b1;
            allowin  = 1'b1;
          end else if (id.id_valid[1]) begin
            state_d = StHalf;
          end else begin
            allowin = 1'b1;
          end
        end else if (!id.id_valid[0]) begin
          // A lone line2 is handled as if line1 had already gone.
          if (id.id_valid[1]) state_d = StHalf;
          else                allowin = 1'b1;
        end
        stall[StallHazard] = l1_ok && id.id_valid[1] && hazard;
        stall[StallSb]     = id.id_valid[0] && l1_busy;
        stall[StallDrain]  = id.id_valid[0] && !drain_idle;
      end
      StHalf: begin
        if (l2_ok) begin
          issue   = 2'b10;
          allowin = 1'b1;
          state_d = StPair;
        end
        stall[StallSb]    = id.id_valid[1] && l2_busy;
        stall[StallDrain] = id.id_valid[1] && !drain_idle;
      end
      default: state_d = StPair;
    endcase
    if (flush_i) begin
      state_d = StPair;
      issue   = 2'b00;
      allowin = 1'b1;
      stall   = 3'b000;
    end
  end

  assign csr_issue    = (issue[0] && id.line1.is_csr) || (issue[1] && id.line2.is_csr);
  assign div_set      = (issue[0] && id.line1.is_div && id.line1.we) ||
                        (issue[1] && id.line2.is_div && id.line2.we);
  assign div_set_addr = (issue[0] && id.line1.is_div) ? id.line1.waddr : id.line2.waddr;

  always_comb begin
    drain_d = drain_q;
    if (csr_issue)        drain_d = CntW'(CSR_DRAIN);
    else if (!drain_idle) drain_d = drain_q - CntW'(1);
    if (flush_i)          drain_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StPair;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  issue_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .set_i        (div_set),
    .set_addr_i   (div_set_addr),
    .clr_i        (div_done_i),
    .clr_addr_i   (div_waddr_i),
    .line1_i      (id.line1),
    .line2_i      (id.line2),
    .line1_busy_o (l1_busy),
    .line2_busy_o (l2_busy)
  );

  assign id.issue       = issue;
  assign id.id_allowin  = allowin;
  assign id.stall_cause = stall;

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: each driven cycle queues its expected outputs,
// a negedge monitor pops and compares them.
module tb_issue_sched;
  import issue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_i = 1'b0;
  logic       ex_allowin_i = 1'b1;
  logic       div_done_i = 1'b0;
  logic [4:0] div_waddr_i = '0;

  issue_sched_if bus();

  issue_sched #(
    .CSR_DRAIN (3),
    .REG_NUM   (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .ex_allowin_i (ex_allowin_i),
    .div_done_i   (div_done_i),
    .div_waddr_i  (div_waddr_i),
    .id           (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] issue;
    logic       allowin;
    logic [2:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(string name, string field, logic [3:0] act, logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %b expected %b at %0t", name, field, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.name, "issue", {2'b00, bus.issue}, {2'b00, e.issue});
      chk(e.name, "allowin", {3'b000, bus.id_allowin}, {3'b000, e.allowin});
      chk(e.name, "stall", {1'b0, bus.stall_cause}, {1'b0, e.stall});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic slot_info_t mk(int we, int wa, int r1e, int r1, int r2e, int r2,
                                    int mem, int dv, int csr);
    slot_info_t s;
    s.we     = (we != 0);
    s.waddr  = 5'(wa);
    s.re1    = (r1e != 0);
    s.raddr1 = 5'(r1);
    s.re2    = (r2e != 0);
    s.raddr2 = 5'(r2);
    s.is_mem = (mem != 0);
    s.is_div = (dv != 0);
    s.is_csr = (csr != 0);
    return s;
  endfunction

  task automatic pair(logic [1:0] v, slot_info_t a, slot_info_t b);
    bus.id_valid = v;
    bus.line1    = a;
    bus.line2    = b;
  endtask

  task automatic step(string name, logic [1:0] iss, logic al, logic [2:0] st);
    exp_t e;
    e.name = name;
    e.issue = iss;
    e.allowin = al;
    e.stall = st;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Independent pair r1<-r2+r3, r4<-r5+r6, presented and consumed.
  task automatic indep(string name);
    pair(2'b11, mk(1, 1, 1, 2, 1, 3, 0, 0, 0), mk(1, 4, 1, 5, 1, 6, 0, 0, 0));
`ifdef ISSUE_SCHED_DUAL_EN
    step({name, "_dual"}, 2'b11, 1'b1, 3'b000);
`else
    step({name, "_l1"}, 2'b01, 1'b0, 3'b000);
    step({name, "_l2"}, 2'b10, 1'b1, 3'b000);
`endif
  endtask

  initial begin
    bus.id_valid = 2'b00;
    bus.line1 = '0;
    bus.line2 = '0;
    bus.line1_read_ready = 1'b1;
    bus.line2_read_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step("reset", 2'b00, 1'b1, 3'b000);
    indep("indep");
    pair(2'b00, '0, '0);
    step("idle", 2'b00, 1'b1, 3'b000);

    // Pair hazards: RAW, both mem, equal destinations
    pair(2'b11, mk(1, 1, 1, 2, 1, 3, 0, 0, 0), mk(1, 7, 1, 1, 0, 0, 0, 0, 0));
    step("raw_l1", 2'b01, 1'b0, 3'b001);
    step("raw_l2", 2'b10, 1'b1, 3'b000);
    pair(2'b11, mk(1, 1, 1, 2, 0, 0, 1, 0, 0), mk(0, 0, 1, 3, 1, 4, 1, 0, 0));
    step("mem_l1", 2'b01, 1'b0, 3'b001);
    step("mem_l2", 2'b10, 1'b1, 3'b000);
    pair(2'b11, mk(1, 3, 1, 2, 0, 0, 0, 0, 0), mk(1, 3, 1, 5, 0, 0, 0, 0, 0));
    step("waw_l1", 2'b01, 1'b0, 3'b001);
    step("waw_l2", 2'b10, 1'b1, 3'b000);

    // EX back-pressure and operand readiness
    pair(2'b11, mk(1, 1, 1, 2, 1, 3, 0, 0, 0), mk(1, 4, 1, 5, 1, 6, 0, 0, 0));
    ex_allowin_i = 1'b0;
    step("ex_block", 2'b00, 1'b0, 3'b000);
    ex_allowin_i = 1'b1;
    bus.line1_read_ready = 1'b0;
    step("rr1_block", 2'b00, 1'b0, 3'b000);
    bus.line1_read_ready = 1'b1;
    bus.line2_read_ready = 1'b0;
    step("rr2_l1", 2'b01, 1'b0, 3'b000);
    step("rr2_half", 2'b00, 1'b0, 3'b000);
    bus.line2_read_ready = 1'b1;
    step("rr2_l2", 2'b10, 1'b1, 3'b000);

    // Divider: r7 busy from t+1 until the cycle after div_done
    pair(2'b01, mk(1, 7, 1, 2, 1, 3, 0, 1, 0), '0);
    step("div_issue", 2'b01, 1'b1, 3'b000);
    pair(2'b01, mk(1, 8, 1, 7, 1, 1, 0, 0, 0), '0);
    for (int i = 0; i < 4; i++) step("div_wait", 2'b00, 1'b0, 3'b010);
    div_done_i = 1'b1;
    div_waddr_i = 5'd7;
    step("div_done_cyc", 2'b00, 1'b0, 3'b010);
    div_done_i = 1'b0;
    step("div_dep_issue", 2'b01, 1'b1, 3'b000);

    // Divide into r0 never marks anything busy
    pair(2'b01, mk(1, 0, 1, 2, 1, 3, 0, 1, 0), '0);
    step("div_r0", 2'b01, 1'b1, 3'b000);
    pair(2'b01, mk(1, 9, 1, 0, 0, 0, 0, 0, 0), '0);
    step("r0_reader", 2'b01, 1'b1, 3'b000);

    // Set and clear of r6 in one cycle: set wins
    pair(2'b01, mk(1, 6, 1, 2, 1, 3, 0, 1, 0), '0);
    div_done_i = 1'b1;
    div_waddr_i = 5'd6;
    step("setwin_div", 2'b01, 1'b1, 3'b000);
    div_done_i = 1'b0;
    pair(2'b01, mk(1, 8, 0, 0, 1, 6, 0, 0, 0), '0);
    step("setwin_block", 2'b00, 1'b0, 3'b010);
    div_done_i = 1'b1;
    step("setwin_done", 2'b00, 1'b0, 3'b010);
    div_done_i = 1'b0;
    step("setwin_issue", 2'b01, 1'b1, 3'b000);

    // CSR in line1: three drain cycles
    pair(2'b01, mk(1, 9, 1, 2, 0, 0, 0, 0, 1), '0);
    step("csr_issue", 2'b01, 1'b1, 3'b000);
    pair(2'b11, mk(1, 1, 1, 2, 1, 3, 0, 0, 0), mk(1, 4, 1, 5, 1, 6, 0, 0, 0));
    for (int i = 0; i < 3; i++) step("csr_drain", 2'b00, 1'b0, 3'b100);
    indep("after_csr");

    // CSR in line2 never pairs and drains after issuing from HALF
    pair(2'b11, mk(1, 1, 1, 2, 1, 3, 0, 0, 0), mk(1, 9, 1, 5, 0, 0, 0, 0, 1));
    step("csr2_l1", 2'b01, 1'b0, 3'b001);
    step("csr2_l2", 2'b10, 1'b1, 3'b000);
    pair(2'b11, mk(1, 1, 1, 2, 1, 3, 0, 0, 0), mk(1, 4, 1, 5, 1, 6, 0, 0, 0));
    for (int i = 0; i < 3; i++) step("csr2_drain", 2'b00, 1'b0, 3'b100);
    indep("after_csr2");

    // Flush in HALF with r5 busy
    pair(2'b01, mk(1, 5, 1, 2, 1, 3, 0, 1, 0), '0);
    step("fl_div", 2'b01, 1'b1, 3'b000);
    pair(2'b11, mk(1, 10, 1, 2, 1, 3, 0, 0, 0), mk(1, 11, 1, 10, 1, 5, 0, 0, 0));
    step("fl_l1", 2'b01, 1'b0, 3'b001);
    step("fl_half", 2'b00, 1'b0, 3'b010);
    flush_i = 1'b1;
    step("flush", 2'b00, 1'b1, 3'b000);
    flush_i = 1'b0;
    pair(2'b01, mk(1, 12, 1, 5, 0, 0, 0, 0, 0), '0);
    step("post_flush", 2'b01, 1'b1, 3'b000);

    // Flush also clears the drain counter
    pair(2'b01, mk(1, 9, 1, 2, 0, 0, 0, 0, 1), '0);
    step("fl_csr", 2'b01, 1'b1, 3'b000);
    pair(2'b11, mk(1, 1, 1, 2, 1, 3, 0, 0, 0), mk(1, 4, 1, 5, 1, 6, 0, 0, 0));
    flush_i = 1'b1;
    step("flush_drain", 2'b00, 1'b1, 3'b000);
    flush_i = 1'b0;
    indep("post_flush_drain");

    pair(2'b00, '0, '0);
    step("final_idle", 2'b00, 1'b1, 3'b000);
    @(negedge clk);
    chk("queue", "pending", 4'(exp_q.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_sched.md
# issue_sched

Dual-issue scheduler sitting between the decode (ID) stage and the operand-forwarding unit of the two-lane in-order pipeline. Each cycle it decides whether the decoded instruction pair issues to EX on both lanes, on one lane, or not at all. It combines intra-pair hazards, the forwarding unit's per-lane read-ready flags, a busy scoreboard for multi-cycle divider results and a drain counter for CSR-class instructions, whose register results are known only in WB. It owns the split-pair state machine that lets line2 of a pair issue one cycle after line1.

## Interface
- `CSR_DRAIN`, 3: cycles issue is blocked after a CSR-class instruction issues.
- `REG_NUM`, 32: architectural GPR count (scoreboard width).
- `clk` in 1: pipeline clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: exception/branch flush from WB; kills ID pair and in-flight divide.
- `ex_allowin_i` in 1: EX can accept this cycle.
- `id_valid_i` in 2: [0]=line1 valid, [1]=line2 valid.
- `lineN_we_i`, `lineN_waddr_i` in 1/5: destination write enable/address (N=1,2).
- `lineN_re1_i`, `lineN_raddr1_i`, `lineN_re2_i`, `lineN_raddr2_i` in 1/5: source reads.
- `lineN_is_mem_i`, `lineN_is_div_i`, `lineN_is_csr_i` in 1: class flags (csr includes ertn/idle/tlb ops).
- `lineN_read_ready_i` in 1: forwarding unit says operands available.
- `div_done_i` in 1, `div_waddr_i` in 5: divider writes back its result.
- `issue_o` out 2: lanes issuing this cycle ([0]=line1, [1]=line2).
- `id_allowin_o` out 1: the current pair is fully consumed; ID may load the next pair.
- `stall_cause_o` out 3: {drain, scoreboard, pair-hazard}, for performance counters.

## Operation
- States: PAIR (no slot of the current pair issued), HALF (line1 issued, line2 pending).
- PAIR: line1 is issuable when valid, read_ready, none of its sources busy in the scoreboard, drain counter is 0 and ex_allowin. Line2 pairs only if line1 issues and line2 is independently issuable.
- Pair hazards that forbid line2 pairing:
  - line2 reads line1 waddr (nonzero, we);
  - equal nonzero destinations;
  - both mem;
  - both div;
  - either is csr.
- PAIR, both issue: issue_o=11, id_allowin_o=1, stay PAIR.
- PAIR, only line1 issues: if line2 is valid, issue_o=01 and go to HALF. If line2 is invalid, issue_o=01, id_allowin_o=1 and stay PAIR.
- HALF: line2 issues alone (issue_o=10) when its issue conditions hold; then id_allowin_o=1 and return to PAIR.
- Scoreboard: the bit for waddr is set when an issued div has we and a nonzero waddr. It clears on div_done_i. If a set and a clear hit the same index in one cycle, the set wins. r0 is never busy.
- Drain counter: loaded with CSR_DRAIN when a csr instruction issues; decrements to 0 each cycle.
- flush_i: issue_o=00, id_allowin_o=1, state→PAIR, scoreboard cleared, counter cleared, all in the next cycle. Flush has priority over every other event.

## Timing
- issue_o, id_allowin_o and stall_cause_o are combinational from the registered state plus the current inputs.
- State, scoreboard and counter update on the rising clk edge.
- Reset values: state=PAIR, scoreboard=0, counter=0. Consequently issue_o=00, id_allowin_o=1 and stall_cause_o=000.
- A div issued in cycle t blocks a dependent reader from t+1 until the cycle after div_done_i.
- A csr issued in cycle t blocks all issue for cycles t+1..t+CSR_DRAIN.

## Configuration
- `ISSUE_SCHED_DUAL_EN` defined: full pairing as above.
- `ISSUE_SCHED_DUAL_EN` undefined: line2 never pairs. Every valid line2 passes through HALF, so issue_o is never 11.

## Structure
- Shared package `issue_pkg`: state enum {PAIR, HALF}, a slot-info struct (we/waddr/re/raddr/class flags), and stall-cause bit indices.
- Sub-module `issue_scoreboard`: REG_NUM-bit busy vector with set/clear/flush ports and two lanes × two source lookups.

## Test plan
- Independent add pair (r1←r2+r3, r4←r5+r6), all ready → issue_o=11 and id_allowin_o=1 in the same cycle.
- line1 r1←…, line2 reads r1 → cycle t: 01, HALF; cycle t+1: 10, allowin=1, back to PAIR.
- div r7 issued, next pair reads r7, div_done_i at t+5 → issue_o=00 with stall_cause[1]=1 until t+5, issue at t+6.
- csrwr in line1, CSR_DRAIN=3 → 01 at t; 00 for t+1..t+3; next pair issues at t+4.
- Flush while in HALF with a div busy bit set → next cycle: PAIR, scoreboard=0, id_allowin_o=1.
- Without ISSUE_SCHED_DUAL_EN, repeat scenario 1 → 01 then 10; 11 never seen.
